// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Wait-cycle counter for the ACCESS phase; expire fires on the wait cycle that reaches LIMIT.
module apb_timeout_ctr
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Combinational so the FSM leaves ACCESS on the same edge the count would reach LIMIT.
    assign expire = inc && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// CPU request/response to APB master bridge (IDLE -> SETUP -> ACCESS).
// Optional ACCESS timeout compiled in with macro APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t state, state_next;
    logic       accept;
    logic       complete;
    logic       timeout;
    logic       expire;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (state == SETUP),
        .inc    ((state == ACCESS) && !PREADY),
        .expire (expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign expire             = 1'b0;
`endif

    // Control outputs decode straight from state so reset clears them immediately.
    assign req_ready = (state == IDLE);
    assign PSEL      = (state != IDLE);
    assign PENABLE   = (state == ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over an expiry on the same edge.
                if (PREADY) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (expire) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= req_write;
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
            end
            rsp_valid <= complete | timeout;
            if (complete) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end else if (timeout) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge; timeout steps run when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_ON = 1;
`else
    localparam int TO_ON = 0;
`endif

    logic        PCLK;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;

    apb_master_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer. Expected response and ACCESS length come from the
    // protocol rules: waits+1 ACCESS cycles, or TO cycles and an error when the
    // timeout is built in and the slave waits too long. Starts just after a posedge.
    task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rdata, input logic err);
        bit          timed_out;
        int          n_access;
        logic [31:0] exp_rdata;
        logic        exp_err;
        timed_out = (TO_ON != 0) && (waits >= TO);
        n_access  = timed_out ? TO : waits + 1;
        exp_rdata = timed_out ? 32'h0 : (wr ? 32'h0 : rdata);
        exp_err   = timed_out ? 1'b1 : err;

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        PREADY    = 1'($urandom);
        PSLVERR   = 1'($urandom);
        PRDATA    = $urandom;
        @(negedge PCLK);
        check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".idle_psel"},  32'(PSEL),      32'd0);

        @(posedge PCLK); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        PREADY    = 1'b1;
        PSLVERR   = 1'($urandom);
        PRDATA    = $urandom;
        @(negedge PCLK);
        check({tag, ".setup_sel"},   {30'd0, PSEL, PENABLE}, 32'd2);
        check({tag, ".setup_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".setup_addr"},  PADDR,  addr);
        check({tag, ".setup_wdata"}, PWDATA, wdata);
        check({tag, ".setup_write"}, 32'(PWRITE), 32'(wr));

        for (int i = 0; i < n_access; i++) begin
            @(posedge PCLK); #1;
            PREADY  = (i == waits);
            PSLVERR = (i == waits) ? err : 1'($urandom);
            PRDATA  = (i == waits) ? rdata : $urandom;
            @(negedge PCLK);
            check($sformatf("%s.access%0d_sel", tag, i), {30'd0, PSEL, PENABLE}, 32'd3);
            check($sformatf("%s.access%0d_addr", tag, i), PADDR, addr);
            check($sformatf("%s.access%0d_wdata", tag, i), PWDATA, wdata);
            check($sformatf("%s.access%0d_rspv", tag, i), 32'(rsp_valid), 32'd0);
        end

        @(posedge PCLK); #1;
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
        @(negedge PCLK);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".rsp_err"},   32'(rsp_err), 32'(exp_err));
        check({tag, ".rsp_sel"},   {30'd0, PSEL, PENABLE}, 32'd0);
        check({tag, ".rsp_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".rsp_addr_hold"}, PADDR, addr);

        @(posedge PCLK); #1;
        @(negedge PCLK);
        check({tag, ".pulse_end"},  32'(rsp_valid), 32'd0);
        check({tag, ".rdata_hold"}, rsp_rdata, exp_rdata);
        check({tag, ".err_hold"},   32'(rsp_err), 32'(exp_err));
        @(posedge PCLK); #1;
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        repeat (2) @(negedge PCLK);
        check("rst.sel",   {30'd0, PSEL, PENABLE}, 32'd0);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.pwrite", 32'(PWRITE), 32'd0);
        check("rst.paddr", PADDR, 32'd0);
        check("rst.pwdata", PWDATA, 32'd0);
        check("rst.rsp", {29'd0, rsp_valid, rsp_err, 1'b0}, 32'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Directed scenarios
        do_xfer("wr_fast", 1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0);
        do_xfer("rd_wait3", 1'b0, 32'h4000_0008, 32'h0, 3, 32'h0000_00A5, 1'b0);
        do_xfer("rd_slverr", 1'b0, 32'h4000_000C, 32'h0, 1, 32'h5555_AAAA, 1'b1);
        do_xfer("wr_ok", 1'b1, 32'h4000_0010, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF, 1'b0);

        // Back-to-back with req_valid held high
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000_0100; req_wdata = 32'h1111_2222;
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0000_0000;
        @(negedge PCLK);
        check("b2b.a_ready", 32'(req_ready), 32'd1);
        @(posedge PCLK); #1;
        req_write = 1'b0; req_addr = 32'h4000_0200; req_wdata = 32'h0; PRDATA = 32'hCAFE_0001;
        @(negedge PCLK);
        check("b2b.a_setup", {30'd0, PSEL, PENABLE}, 32'd2);
        check("b2b.a_busy", 32'(req_ready), 32'd0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("b2b.a_access", {30'd0, PSEL, PENABLE}, 32'd3);
        check("b2b.a_addr", PADDR, 32'h4000_0100);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("b2b.a_rsp", {30'd0, rsp_valid, req_ready}, 32'd3);
        check("b2b.a_idle_gap", 32'(PSEL), 32'd0);
        check("b2b.a_rdata", rsp_rdata, 32'd0);
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        @(negedge PCLK);
        check("b2b.b_setup", {30'd0, PSEL, PENABLE}, 32'd2);
        check("b2b.b_addr", PADDR, 32'h4000_0200);
        check("b2b.b_nopulse", 32'(rsp_valid), 32'd0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("b2b.b_access", {30'd0, PSEL, PENABLE}, 32'd3);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("b2b.b_rsp", 32'(rsp_valid), 32'd1);
        check("b2b.b_rdata", rsp_rdata, 32'hCAFE_0001);
        @(posedge PCLK); #1;

        // Reset pulsed in the middle of ACCESS
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0300; PREADY = 1'b0;
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("rstmid.in_access", {30'd0, PSEL, PENABLE}, 32'd3);
        #2;
        PRESETn = 1'b0;
        #1;
        check("rstmid.sel_async", {30'd0, PSEL, PENABLE}, 32'd0);
        check("rstmid.ready", 32'(req_ready), 32'd1);
        check("rstmid.paddr", PADDR, 32'd0);
        PREADY = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check($sformatf("rstmid.no_rsp%0d", i), {30'd0, rsp_valid, PSEL}, 32'd0);
        end
        @(posedge PCLK); #1;
        do_xfer("after_rst", 1'b1, 32'h4000_0400, 32'h7777_8888, 2, 32'h0, 1'b1);

`ifdef APB_MASTER_TIMEOUT_EN
        do_xfer("to_stuck", 1'b0, 32'h4000_0500, 32'h0, 100, 32'hABCD_0000, 1'b0);
        do_xfer("to_ready4", 1'b0, 32'h4000_0504, 32'h0, TO - 1, 32'h0000_5A5A, 1'b1);
        do_xfer("to_ready4w", 1'b1, 32'h4000_0508, 32'h9, TO - 1, 32'h0000_5A5A, 1'b0);
`endif

        // Randomized transfers
        for (int n = 0; n < 12; n++) begin
            do_xfer($sformatf("rnd%0d", n), 1'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 5)), $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
